led_pattern_gen: RTL and testbench

Parametrised multi-channel LED pattern generator for the soc_clocks family of board test designs. It sits behind a gclkbuff-buffered fabric clock and generalises the fixed "counter bit to LED" heartbeat to CHANNELS outputs. One shared prescaler counter drives all channels. Each channel is independently configured at run time as off, on, blink (selectable counter tap) or breathe (triangle-ramped PWM).

---
 rtl/led_pattern_gen.sv | 102 ++++++++++
 tb/tb_led_pattern_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: one shared prescaler feeding per-channel
// off/on/blink/breathe selectors with run-time configuration.
module led_pattern_gen #(
  parameter  int CHANNELS  = 4,
  parameter  int CNT_WIDTH = 24,
  parameter  int PWM_WIDTH = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TAP_W     = $clog2(CNT_WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sync_clr,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [TAP_W-1:0]    cfg_tap,
  output logic [CHANNELS-1:0] led,
  output logic                tick
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  logic [CNT_WIDTH-1:0] cnt;
  mode_t                mode [CHANNELS];
  logic [TAP_W-1:0]     tap  [CHANNELS];
  logic [CHANNELS-1:0]  led_nxt;
  logic                 pwm_on;

  // Taps beyond the counter width would select a nonexistent bit.
  function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] t);
    if (32'(t) >= 32'(CNT_WIDTH)) return TAP_W'(CNT_WIDTH - 1);
    return t;
  endfunction

  // Triangle duty from the top counter bits, compared against the low bits.
  function automatic logic breathe_on(input logic [CNT_WIDTH-1:0] c);
    logic [PWM_WIDTH:0]   ph;
    logic [PWM_WIDTH-1:0] duty;
    ph   = c[CNT_WIDTH-1 -: PWM_WIDTH+1];
    duty = ph[PWM_WIDTH] ? ~ph[PWM_WIDTH-1:0] : ph[PWM_WIDTH-1:0];
    return c[PWM_WIDTH-1:0] < duty;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (&cnt) && en && !sync_clr;
      if (sync_clr)
        cnt <= '0;
      else if (en)
        cnt <= cnt + 1'b1;
    end
  end

  // Out-of-range channel indices match no loop iteration and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i] <= MODE_BLINK;
        tap[i]  <= TAP_W'(CNT_WIDTH - 3);
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          mode[i] <= mode_t'(cfg_mode);
          tap[i]  <= clamp_tap(cfg_tap);
        end
      end
    end
  end

  assign pwm_on = breathe_on(cnt);

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (mode[i])
        MODE_OFF:     led_nxt[i] = 1'b0;
        MODE_ON:      led_nxt[i] = 1'b1;
        MODE_BLINK:   led_nxt[i] = cnt[tap[i]];
        MODE_BREATHE: led_nxt[i] = pwm_on;
        default:      led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      led <= '0;
    else
      led <= led_nxt;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances (4ch/8-bit, 3ch/10-bit) driven in
// parallel and checked every cycle against an arithmetic model.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       sync_clr = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_tap = '0;
  logic [3:0] led_a;
  logic [2:0] led_b;
  logic       tick_a, tick_b;

  int  n_chk = 0;
  int  n_pass = 0;
  bit  chk_on = 1'b0;

  led_pattern_gen #(.CHANNELS(4), .CNT_WIDTH(8), .PWM_WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_tap(cfg_tap[2:0]),
    .led(led_a), .tick(tick_a));

  led_pattern_gen #(.CHANNELS(3), .CNT_WIDTH(10), .PWM_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_tap(cfg_tap),
    .led(led_b), .tick(tick_b));

  always #5 clk = ~clk;

  function automatic int cw_of(int k);  return (k == 0) ? 8 : 10; endfunction
  function automatic int nch_of(int k); return (k == 0) ? 4 : 3;  endfunction
  function automatic int tw_of(int k);  return (k == 0) ? 3 : 4;  endfunction
  localparam int PW = 4;

  // Reference state
  int   m_cnt  [2];
  int   m_mode [2][4];
  int   m_tap  [2][4];
  logic m_led  [2][4];
  logic m_tick [2];

  function automatic logic model_led(int k, int md, int tp, int c);
    int ph, top, duty;
    top  = 1 << PW;
    ph   = c >> (cw_of(k) - PW - 1);
    duty = (ph < top) ? ph : (2 * top - 1 - ph);
    case (md)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((c >> tp) & 1) != 0;
      default: return (c % top) < duty;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k]  = 0;
        m_tick[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          m_mode[k][i] = 2;
          m_tap[k][i]  = cw_of(k) - 3;
          m_led[k][i]  = 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int t;
        for (int i = 0; i < nch_of(k); i++)
          m_led[k][i] = model_led(k, m_mode[k][i], m_tap[k][i], m_cnt[k]);
        m_tick[k] = en && !sync_clr && (m_cnt[k] == (1 << cw_of(k)) - 1);
        if (sync_clr)  m_cnt[k] = 0;
        else if (en)   m_cnt[k] = (m_cnt[k] + 1) % (1 << cw_of(k));
        if (cfg_we && int'(cfg_ch) < nch_of(k)) begin
          t = int'(cfg_tap) % (1 << tw_of(k));
          if (t >= cw_of(k)) t = cw_of(k) - 1;
          m_mode[k][int'(cfg_ch)] = int'(cfg_mode);
          m_tap[k][int'(cfg_ch)]  = t;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("led_a", 32'(led_a), 32'({m_led[0][3], m_led[0][2], m_led[0][1], m_led[0][0]}));
      chk("led_b", 32'(led_b), 32'({m_led[1][2], m_led[1][1], m_led[1][0]}));
      chk("tick_a", 32'(tick_a), 32'(m_tick[0]));
      chk("tick_b", 32'(tick_b), 32'(m_tick[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int md, input int tp);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_mode = 2'(md);
    cfg_tap  = 4'(tp);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic clr_pulse();
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
  endtask

  int ones [3];

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_led_a", 32'(led_a), 32'h0);
    chk("rst_led_b", 32'(led_b), 32'h0);
    chk("rst_tick", 32'({tick_a, tick_b}), 32'h0);
    chk_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Default blink on bit 5: first rise one cycle after cnt reaches 32
    cyc(32);
    chk("blink_pre32_a", 32'(led_a), 32'h0);
    chk("blink_pre32_b", 32'(led_b), 32'h0);
    cyc(1);
    chk("blink_rise_a", 32'(led_a), 32'hF);
    cyc(7);

    // Full wrap of the 8-bit prescaler
    clr_pulse();
    cyc(255);
    chk("tick_before_wrap", 32'(tick_a), 32'h0);
    cyc(1);
    chk("tick_at_wrap", 32'(tick_a), 32'h1);
    chk("tick_b_no_wrap", 32'(tick_b), 32'h0);
    cyc(1);
    chk("tick_one_cycle", 32'(tick_a), 32'h0);

    // Mode writes
    wr(1, 1, 0);
    cyc(1);
    chk("ch1_on", 32'(led_a[1]), 32'h1);
    wr(2, 0, 0);
    cyc(1);
    chk("ch2_off", 32'(led_a[2]), 32'h0);
    wr(3, 2, 12);
    cyc(20);

    // Index 3 exists only in the 4-channel instance
    wr(0, 0, 0);
    wr(1, 0, 0);
    wr(2, 0, 0);
    wr(3, 1, 0);
    cyc(1);
    chk("ch3_on_a", 32'(led_a), 32'h8);
    chk("ch3_ignored_b", 32'(led_b), 32'h0);
    wr(5, 1, 0);
    cyc(1);
    chk("ch5_trunc_a", 32'(led_a), 32'hA);
    chk("ch5_trunc_b", 32'(led_b), 32'h2);

    // Breathe: duty steps every 8 counts at this width
    wr(0, 3, 0);
    clr_pulse();
    for (int k = 0; k < 3; k++) ones[k] = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i < 16)                ones[0] += int'(led_a[0]);
      if (i >= 112 && i < 128)   ones[1] += int'(led_a[0]);
      if (i >= 240)              ones[2] += int'(led_a[0]);
    end
    chk("breathe_0_15", 32'(ones[0]), 32'd0);
    chk("breathe_112_127", 32'(ones[1]), 32'd15);
    chk("breathe_240_255", 32'(ones[2]), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom % 8) != 0;
      sync_clr = ($urandom % 64) == 0;
      cfg_we   = ($urandom % 6) == 0;
      cfg_ch   = 2'($urandom);
      cfg_mode = 2'($urandom);
      cfg_tap  = 4'($urandom);
      @(negedge clk);
    end
    cfg_we   = 1'b0;
    sync_clr = 1'b0;
    en       = 1'b1;

    // sync_clr at cnt=100 with a concurrent write, then async reset
    for (int c = 0; c < 4; c++) wr(c, 1, 0);
    clr_pulse();
    cyc(100);
    sync_clr = 1'b1;
    wr(2, 2, 0);
    sync_clr = 1'b0;
    cyc(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led_a", 32'(led_a), 32'h0);
    chk("async_rst_led_b", 32'(led_b), 32'h0);
    chk("async_rst_tick", 32'({tick_a, tick_b}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(32);
    chk("post_rst_blink_lo", 32'(led_a), 32'h0);
    cyc(1);
    chk("post_rst_blink_hi", 32'(led_a), 32'hF);
    cyc(4);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
